// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - opcode, funct and ALU/immediate encodings shared by the riscv_cpu block
package riscv_cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_t alu_op_from(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_cpu_reg_file.sv
// rtl/riscv_cpu_reg_file.sv - 32x32 register file, two combinational reads, one synchronous write
module reg_file
  import riscv_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : registers[raddr2];

endmodule

// File: rtl/riscv_cpu.sv
// rtl/riscv_cpu.sv - single-cycle RV32I core (word loads/stores only) with external ROM and RAM
module riscv_cpu
  import riscv_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_sig,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mem_addr,
  output logic [31:0] rom_addr
);

  logic [31:0] pc, pc_next, pc_plus4, pc_target;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_result, wb_data;
  logic [4:0]  shamt;
  logic        reg_we, mem_we, a_pc, b_imm, is_branch, is_jal, is_jalr, taken;
  imm_sel_t    imm_sel;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  // Anything not matched below (including byte/halfword memory ops) stays a NOP
  always_comb begin
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    a_pc      = 1'b0;
    b_imm     = 1'b0;
    imm_sel   = IMM_I;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        reg_we = 1'b1; imm_sel = IMM_U; b_imm = 1'b1; alu_op = ALU_PASS_B;
      end
      OP_AUIPC: begin
        reg_we = 1'b1; imm_sel = IMM_U; b_imm = 1'b1; a_pc = 1'b1;
      end
      OP_JAL: begin
        reg_we = 1'b1; imm_sel = IMM_J; wb_sel = WB_PC4; is_jal = 1'b1;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        reg_we = 1'b1; b_imm = 1'b1; wb_sel = WB_PC4; is_jalr = 1'b1;
      end
      OP_BRANCH: if (funct3[2:1] != 2'b01) begin
        imm_sel = IMM_B; is_branch = 1'b1;
      end
      OP_LOAD: if (funct3 == F3_WORD) begin
        reg_we = 1'b1; b_imm = 1'b1; wb_sel = WB_MEM;
      end
      OP_STORE: if (funct3 == F3_WORD) begin
        mem_we = 1'b1; b_imm = 1'b1; imm_sel = IMM_S;
      end
      OP_IMM: begin
        b_imm  = 1'b1;
        alu_op = alu_op_from(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)      reg_we = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) reg_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                       reg_we = 1'b1;
      end
      OP_REG: begin
        alu_op = alu_op_from(funct3, funct7[5]);
        reg_we = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      default: ;
    endcase
  end

  always_comb begin
    case (imm_sel)
      IMM_S:   imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B:   imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      IMM_U:   imm = {instruction[31:12], 12'b0};
      IMM_J:   imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: imm = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

  reg_file reg_file_inst (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (reg_we),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  assign alu_a = a_pc ? pc : rs1_val;
  assign alu_b = b_imm ? imm : rs2_val;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:    alu_result = alu_a + alu_b;
      ALU_SUB:    alu_result = alu_a - alu_b;
      ALU_SLL:    alu_result = alu_a << shamt;
      ALU_SLT:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_result = {31'b0, alu_a < alu_b};
      ALU_XOR:    alu_result = alu_a ^ alu_b;
      ALU_SRL:    alu_result = alu_a >> shamt;
      ALU_SRA:    alu_result = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:     alu_result = alu_a | alu_b;
      ALU_AND:    alu_result = alu_a & alu_b;
      ALU_PASS_B: alu_result = alu_b;
      default:    alu_result = '0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val < rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm;

  always_comb begin
    pc_next = pc_plus4;
    if (is_jalr)                    pc_next = alu_result & ~32'd1;
    else if (is_jal)                pc_next = pc_target;
    else if (is_branch && taken)    pc_next = pc_target;
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_rd_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= '0;
    else          pc <= pc_next;
  end

  assign rom_addr    = pc;
  assign mem_addr    = alu_result;
  assign mem_wr_data = rs2_val;
  assign mem_wr_sig  = mem_we & reset_n;

endmodule

// File: tb/tb_riscv_cpu.sv
// tb/tb_riscv_cpu.sv - bench for riscv_cpu: directed programs plus random programs against an ISS
module tb_riscv_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction, mem_rd_data, mem_wr_data, mem_addr, rom_addr;
  logic        mem_wr_sig;

  logic [31:0] rom [0:255];
  logic [31:0] ram [0:255];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_ram [0:255];
  logic [31:0] m_pc;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instruction = rom[rom_addr[9:2]];
  assign mem_rd_data = ram[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr_sig === 1'b1) ram[mem_addr[9:2]] <= mem_wr_data;

  riscv_cpu cpu_inst (
    .clk        (clk),
    .reset_n    (reset_n),
    .instruction(instruction),
    .mem_rd_data(mem_rd_data),
    .mem_wr_sig (mem_wr_sig),
    .mem_wr_data(mem_wr_data),
    .mem_addr   (mem_addr),
    .rom_addr   (rom_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  // Reference arithmetic straight from the ISA definitions
  function automatic logic [31:0] alu_ref(logic [2:0] f3, bit alt, logic [31:0] x, logic [31:0] y);
    case (f3)
      3'd0:    return alt ? x - y : x + y;
      3'd1:    return x << y[4:0];
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic model_exec(output bit st, output logic [31:0] sa, output logic [31:0] sd);
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, nx, res, la;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    bit wr, tk, ok;
    ins = rom[m_pc[9:2]];
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
    a  = m_reg[ins[19:15]];
    b  = m_reg[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nx = m_pc + 32'd4; wr = 0; res = '0; st = 0; sa = a + is; sd = b;
    case (op)
      7'h37: begin wr = 1; res = iu; end
      7'h17: begin wr = 1; res = m_pc + iu; end
      7'h6f: begin wr = 1; res = m_pc + 32'd4; nx = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1; res = m_pc + 32'd4; nx = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 0;
        endcase
        if (tk) nx = m_pc + ib;
      end
      7'h03: if (f3 == 3'd2) begin la = a + ii; wr = 1; res = m_ram[la[9:2]]; end
      7'h23: if (f3 == 3'd2) st = 1;
      7'h13: begin
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                 ok = 1;
        if (ok) begin wr = 1; res = alu_ref(f3, (f3 == 3'd5) && f7[5], a, ii); end
      end
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (ok) begin wr = 1; res = alu_ref(f3, f7[5], a, b); end
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_reg[rd] = res;
    if (st) m_ram[sa[9:2]] = sd;
    m_pc = nx;
  endtask

  // Called at a falling edge; compares the cycle's fetch/store then lets one rising edge pass
  task automatic run_lockstep(input int n);
    bit st;
    logic [31:0] sa, sd;
    for (int c = 0; c < n; c++) begin
      chk("pc", rom_addr, m_pc);
      model_exec(st, sa, sd);
      chk("wr_sig", {31'b0, mem_wr_sig}, {31'b0, st});
      if (st) begin
        chk("st_addr", mem_addr, sa);
        chk("st_data", mem_wr_data, sd);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic compare_regs(input string tag);
    for (int i = 1; i < 32; i++)
      chk($sformatf("%s_x%0d", tag, i), cpu_inst.reg_file_inst.registers[i], m_reg[i]);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h00000013;
  endtask

  task automatic do_reset(input bit check_regs);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rom_addr", rom_addr, 32'd0);
    chk("rst_wr_sig", {31'b0, mem_wr_sig}, 32'd0);
    if (check_regs)
      for (int i = 1; i < 32; i++)
        chk($sformatf("rst_x%0d", i), cpu_inst.reg_file_inst.registers[i], 32'd0);
    @(negedge clk);
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < 256; i++) m_ram[i] = ram[i];
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, s;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [11:0] im;
    logic [12:0] bo;
    logic [20:0] jo;
    r = $urandom; s = $urandom;
    rd = {1'b0, r[3:0]}; r1 = {1'b0, r[7:4]}; r2 = {1'b0, r[11:8]};
    f3 = r[14:12]; im = s[11:0];
    case ($urandom_range(0, 10))
      0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[15]) ? 7'h20 : 7'h00, r2, r1, f3, rd);
      2, 3: begin
        if (f3 == 3'd1) im[11:5] = 7'h00;
        if (f3 == 3'd5) im[11:5] = r[15] ? 7'h20 : 7'h00;
        return enc_i(im, r1, f3, rd, 7'h13);
      end
      4: return {s[31:12], rd, r[16] ? 7'h37 : 7'h17};
      5: return enc_i(im, r1, 3'b010, rd, 7'h03);
      6: return enc_s(im, r2, r1);
      7: begin
        bo = 13'($urandom_range(1, 4) * 4);
        if (r[20]) bo = -bo;
        return enc_b(bo, r2, r1, f3);
      end
      8: begin
        jo = 21'($urandom_range(1, 4) * 4);
        return enc_j(jo, rd);
      end
      9: return enc_i(im, r1, 3'b000, rd, 7'h67);
      default: return s;
    endcase
  endfunction

  initial begin
    clear_rom();
    for (int i = 0; i < 256; i++) ram[i] = '0;

    // ALU basics and x0 discard
    rom[0] = addi(5'd1, 5'd0, 12'hffb);
    rom[1] = addi(5'd2, 5'd0, 12'd3);
    rom[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    rom[3] = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd4);
    rom[4] = enc_i(12'd1 | 12'h400, 5'd1, 3'b101, 5'd5, 7'h13);
    rom[5] = addi(5'd0, 5'd0, 12'd7);
    do_reset(1'b1);
    run_lockstep(6);
    chk("alu_x3", cpu_inst.reg_file_inst.registers[3], 32'hFFFFFFFE);
    chk("alu_x4", cpu_inst.reg_file_inst.registers[4], 32'd1);
    chk("alu_x5", cpu_inst.reg_file_inst.registers[5], 32'hFFFFFFFD);
    chk("alu_x0", cpu_inst.reg_file_inst.registers[0], 32'd0);
    chk("alu_pc", rom_addr, 32'h18);

    // Store then load through RAM
    clear_rom();
    rom[0] = addi(5'd1, 5'd0, 12'h040);
    rom[1] = addi(5'd2, 5'd0, 12'd123);
    rom[2] = enc_s(12'd4, 5'd2, 5'd1);
    rom[3] = enc_i(12'd4, 5'd1, 3'b010, 5'd3, 7'h03);
    do_reset(1'b1);
    run_lockstep(2);
    chk("sw_sig", {31'b0, mem_wr_sig}, 32'd1);
    chk("sw_addr", mem_addr, 32'h44);
    chk("sw_data", mem_wr_data, 32'd123);
    run_lockstep(2);
    chk("lw_x3", cpu_inst.reg_file_inst.registers[3], 32'd123);
    chk("ram_word", ram[17], 32'd123);

    // Branches: beq taken, blt signed taken, bltu not taken
    clear_rom();
    rom[0] = addi(5'd1, 5'd0, 12'd5);
    rom[1] = addi(5'd2, 5'd0, 12'd5);
    rom[2] = enc_b(13'd8, 5'd2, 5'd1, 3'b000);
    rom[3] = addi(5'd3, 5'd0, 12'd1);
    rom[4] = addi(5'd4, 5'd0, 12'hfff);
    rom[5] = addi(5'd5, 5'd0, 12'd1);
    rom[6] = enc_b(13'd8, 5'd5, 5'd4, 3'b100);
    rom[7] = addi(5'd6, 5'd0, 12'd1);
    rom[8] = enc_b(13'd8, 5'd5, 5'd4, 3'b110);
    rom[9] = addi(5'd7, 5'd0, 12'd1);
    do_reset(1'b0);
    run_lockstep(8);
    chk("beq_skip_x3", cpu_inst.reg_file_inst.registers[3], 32'd0);
    chk("blt_skip_x6", cpu_inst.reg_file_inst.registers[6], 32'd0);
    chk("bltu_fall_x7", cpu_inst.reg_file_inst.registers[7], 32'd1);
    chk("br_pc", rom_addr, 32'h28);

    // JAL link and JALR return
    clear_rom();
    rom[4] = enc_j(21'd12, 5'd1);
    rom[7] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'h67);
    do_reset(1'b0);
    run_lockstep(5);
    chk("jal_pc", rom_addr, 32'h1C);
    chk("jal_x1", cpu_inst.reg_file_inst.registers[1], 32'h14);
    run_lockstep(1);
    chk("jalr_pc", rom_addr, 32'h14);

    // Reset asserted during a store aborts the write
    clear_rom();
    ram[16] = 32'hDEADBEEF;
    rom[0] = addi(5'd1, 5'd0, 12'h040);
    rom[1] = addi(5'd2, 5'd0, 12'd77);
    rom[2] = enc_s(12'd0, 5'd2, 5'd1);
    do_reset(1'b0);
    run_lockstep(2);
    reset_n = 1'b0;
    #1;
    chk("abort_wr_sig", {31'b0, mem_wr_sig}, 32'd0);
    chk("abort_pc", rom_addr, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_ram", ram[16], 32'hDEADBEEF);
    chk("abort_x2", cpu_inst.reg_file_inst.registers[2], 32'd0);
    @(negedge clk);

    // Recursive sum of 1..10 with a stack in RAM
    clear_rom();
    rom[0]  = addi(5'd2, 5'd0, 12'h200);
    rom[1]  = addi(5'd10, 5'd0, 12'd10);
    rom[2]  = enc_j(21'd12, 5'd1);
    rom[3]  = addi(5'd29, 5'd10, 12'd0);
    rom[4]  = enc_j(21'd0, 5'd0);
    rom[5]  = addi(5'd2, 5'd2, 12'hff8);
    rom[6]  = enc_s(12'd4, 5'd1, 5'd2);
    rom[7]  = enc_s(12'd0, 5'd10, 5'd2);
    rom[8]  = enc_b(13'd12, 5'd0, 5'd10, 3'b001);
    rom[9]  = addi(5'd2, 5'd2, 12'd8);
    rom[10] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'h67);
    rom[11] = addi(5'd10, 5'd10, 12'hfff);
    rom[12] = enc_j(21'h1FFFE4, 5'd1);
    rom[13] = enc_i(12'd0, 5'd2, 3'b010, 5'd5, 7'h03);
    rom[14] = enc_r(7'h00, 5'd5, 5'd10, 3'b000, 5'd10);
    rom[15] = enc_i(12'd4, 5'd2, 3'b010, 5'd1, 7'h03);
    rom[16] = addi(5'd2, 5'd2, 12'd8);
    rom[17] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'h67);
    do_reset(1'b0);
    run_lockstep(400);
    chk("sum_x29", cpu_inst.reg_file_inst.registers[29], 32'd55);
    compare_regs("sum");

    // Random programs checked instruction by instruction against the ISS
    for (int t = 0; t < 6; t++) begin
      logic [31:0] r;
      clear_rom();
      for (int i = 0; i < 256; i++) ram[i] = $urandom;
      for (int k = 1; k <= 8; k++) begin
        r = $urandom;
        rom[2*k-2] = {r[31:12], 5'(k), 7'h37};
        rom[2*k-1] = addi(5'(k), 5'(k), r[11:0]);
      end
      for (int i = 16; i < 80; i++) rom[i] = rand_instr();
      do_reset(1'b0);
      run_lockstep(150);
      compare_regs($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
